// File: rtl/mem_stage.sv
// Memory stage: unpacks the EX/MEM buffer, runs the data-memory req/ack access and registers the MEM/WB buffer.
// Optional access timeout with a sticky error flag is enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
   parameter int unsigned N       = 4,
   parameter int unsigned BW      = 26,
   parameter int unsigned OW      = 14,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [BW-1:0] bufferIn,
   output logic          memReq,
   output logic          memWe,
   output logic [N-1:0]  memAddr,
   output logic [N-1:0]  memWdata,
   input  logic          memAck,
   input  logic [N-1:0]  memRdata,
   output logic          stall,
   output logic [OW-1:0] bufferOut,
   output logic          fwdRegWrite,
   output logic [3:0]    fwdRc,
   output logic [N-1:0]  fwdValue,
   output logic          memError
);

   localparam int unsigned RC_LSB  = N;
   localparam int unsigned RW_BIT  = N + 12;
   localparam int unsigned MTR_BIT = N + 13;
   localparam int unsigned MW_BIT  = N + 14;
   localparam int unsigned ALU_LSB = N + 18;
   localparam int unsigned O_MD    = N;
   localparam int unsigned O_RC    = 2 * N;
   localparam int unsigned O_RW    = 2 * N + 4;
   localparam int unsigned O_MTR   = 2 * N + 5;

   typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [OW-1:0]  buf_q, buf_d;
   logic           req_q, req_d;
   logic           we_q, we_d;
   logic [N-1:0]   addr_q, addr_d;
   logic [N-1:0]   wdata_q, wdata_d;
   logic [N-1:0]   hold_alu_q, hold_alu_d;
   logic [3:0]     hold_rc_q, hold_rc_d;
   logic           hold_rw_q, hold_rw_d;
   logic           hold_mtr_q, hold_mtr_d;
   logic           timeout_hit;

   logic [N-1:0]   in_rd3;
   logic [3:0]     in_rc;
   logic           in_rw;
   logic           in_mtr;
   logic           in_mw;
   logic [N-1:0]   in_alu;
   logic           is_mem;
   logic           unused_fields;

   assign in_rd3 = bufferIn[N-1:0];
   assign in_rc  = bufferIn[RC_LSB+3:RC_LSB];
   assign in_rw  = bufferIn[RW_BIT];
   assign in_mtr = bufferIn[MTR_BIT];
   assign in_mw  = bufferIn[MW_BIT];
   assign in_alu = bufferIn[ALU_LSB+N-1:ALU_LSB];
   assign is_mem = in_mtr | in_mw;
   // Ra, Rb and the ALU flags are consumed upstream
   assign unused_fields = ^{bufferIn[N+11:N+4], bufferIn[N+17:N+15]};

   // State and pipeline registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hold_alu_q <= '0;
         hold_rc_q  <= '0;
         hold_rw_q  <= 1'b0;
         hold_mtr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hold_alu_q <= hold_alu_d;
         hold_rc_q  <= hold_rc_d;
         hold_rw_q  <= hold_rw_d;
         hold_mtr_q <= hold_mtr_d;
      end
   end

   // Next-state: the ack path is not gated by en so the memory side always completes
   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      hold_alu_d = hold_alu_q;
      hold_rc_d  = hold_rc_q;
      hold_rw_d  = hold_rw_q;
      hold_mtr_d = hold_mtr_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               if (is_mem) begin
                  state_d    = ACCESS;
                  hold_alu_d = in_alu;
                  hold_rc_d  = in_rc;
                  hold_rw_d  = in_rw;
                  hold_mtr_d = in_mtr & ~in_mw;
                  addr_d     = in_alu;
                  wdata_d    = in_rd3;
                  we_d       = in_mw;
                  req_d      = 1'b1;
                  buf_d      = '0;
               end else begin
                  buf_d = {1'b0, in_rw, in_rc, N'(0), in_alu};
               end
            end
         end
         ACCESS: begin
            if (memAck) begin
               state_d = IDLE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               buf_d   = {hold_mtr_q, hold_rw_q, hold_rc_q,
                          (we_q ? N'(0) : memRdata), hold_alu_q};
            end else if (timeout_hit) begin
               state_d = IDLE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               buf_d   = {hold_mtr_q, 1'b0, hold_rc_q, N'(0), hold_alu_q};
            end else if (en) begin
               buf_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stall and forwarding outputs
   always_comb begin
      stall = 1'b0;
      if (rst) begin
         case (state_q)
            IDLE:    stall = en & is_mem;
            ACCESS:  stall = ~memAck & ~timeout_hit;
            default: stall = 1'b0;
         endcase
      end
   end

   assign memReq      = req_q;
   assign memWe       = we_q;
   assign memAddr     = addr_q;
   assign memWdata    = wdata_q;
   assign bufferOut   = buf_q;
   assign fwdRegWrite = buf_q[O_RW];
   assign fwdRc       = buf_q[O_RC+3:O_RC];
   assign fwdValue    = buf_q[O_MTR] ? buf_q[O_MD+N-1:O_MD] : buf_q[N-1:0];

`ifdef MEM_STAGE_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   assign timeout_hit = (state_q == ACCESS) && en && !memAck && (cnt_q == CW'(TIMEOUT - 1));

   // Cycles spent in ACCESS without ack; cleared whenever the access ends
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == ACCESS) begin
         if (memAck || timeout_hit) cnt_d = '0;
         else if (en)               cnt_d = cnt_q + CW'(1);
      end
      if (timeout_hit) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign memError = err_q;
`else
   logic [$clog2(TIMEOUT+1)-1:0] unused_timeout;

   assign unused_timeout = '0;
   assign timeout_hit    = 1'b0;
   assign memError       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus queues expected MEM/WB entries, a monitor pops them as they appear.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [25:0] bufferIn;
   logic        memReq, memWe;
   logic [3:0]  memAddr, memWdata;
   logic        memAck;
   logic [3:0]  memRdata;
   logic        stall;
   logic [13:0] bufferOut;
   logic        fwdRegWrite;
   logic [3:0]  fwdRc;
   logic [3:0]  fwdValue;
   logic        memError;

   int          checks = 0;
   int          errors = 0;
   logic [13:0] sb[$];
   logic        stim_done = 1'b0;

   mem_stage #(.N(4), .BW(26), .OW(14), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .en(en), .bufferIn(bufferIn),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
      .memAck(memAck), .memRdata(memRdata), .stall(stall), .bufferOut(bufferOut),
      .fwdRegWrite(fwdRegWrite), .fwdRc(fwdRc), .fwdValue(fwdValue), .memError(memError)
   );

   always #5 clk = ~clk;

   function automatic logic [25:0] mk(input logic [3:0] rd3, input logic [3:0] rc,
                                      input logic rw, input logic mtr, input logic mw,
                                      input logic [3:0] alu);
      // Ra=A, Rb=B, flags=101 are filler that must not leak downstream
      return {alu, 3'b101, mw, mtr, rw, 4'hA, 4'hB, rc, rd3};
   endfunction

   function automatic logic [13:0] mko(input logic [3:0] alu, input logic [3:0] md,
                                       input logic [3:0] rc, input logic rw, input logic mtr);
      return {mtr, rw, rc, md, alu};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      logic [13:0] prev = '0;
      logic [13:0] exp;
      while (!stim_done) begin
         @(negedge clk);
         if (rst && bufferOut !== prev && bufferOut != 14'd0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got %0h expected none", bufferOut);
            end else begin
               exp = sb.pop_front();
               chk("sb_bufferOut", 32'(bufferOut), 32'(exp));
            end
         end
         prev = bufferOut;
      end
   endtask

   task automatic stimulus();
      rst = 1'b0; en = 1'b0; bufferIn = '0; memAck = 1'b0; memRdata = '0;
      tick(); tick();
      // Reset state; a load presented during reset must not stall or issue
      en = 1'b1; bufferIn = mk(4'h0, 4'h2, 1'b1, 1'b1, 1'b0, 4'h5);
      @(negedge clk);
      chk("rst_bufferOut", 32'(bufferOut), 32'd0);
      chk("rst_memReq", 32'(memReq), 32'd0);
      chk("rst_memWe", 32'(memWe), 32'd0);
      chk("rst_memAddr", 32'(memAddr), 32'd0);
      chk("rst_memWdata", 32'(memWdata), 32'd0);
      chk("rst_memError", 32'(memError), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      tick();
      // ALU pass-through
      rst = 1'b1; bufferIn = mk(4'h0, 4'h3, 1'b1, 1'b0, 1'b0, 4'h4);
      sb.push_back(mko(4'h4, 4'h0, 4'h3, 1'b1, 1'b0));
      @(negedge clk);
      chk("rst_load_memReq", 32'(memReq), 32'd0);
      chk("pass_stall", 32'(stall), 32'd0);
      tick();
      // Enable hold over three edges
      en = 1'b0; bufferIn = mk(4'h0, 4'h1, 1'b1, 1'b0, 1'b0, 4'h6);
      @(negedge clk);
      chk("pass_fwdValue", 32'(fwdValue), 32'd4);
      chk("pass_fwdRc", 32'(fwdRc), 32'd3);
      chk("pass_fwdRegWrite", 32'(fwdRegWrite), 32'd1);
      chk("pass_memReq", 32'(memReq), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("hold_bufferOut", 32'(bufferOut), 32'(mko(4'h4, 4'h0, 4'h3, 1'b1, 1'b0)));
         chk("hold_stall", 32'(stall), 32'd0);
      end
      tick();
      en = 1'b1;
      sb.push_back(mko(4'h6, 4'h0, 4'h1, 1'b1, 1'b0));
      tick();
      // Load, ack two cycles after the request appears
      bufferIn = mk(4'hA, 4'h2, 1'b1, 1'b1, 1'b0, 4'h5);
      sb.push_back(mko(4'h5, 4'h9, 4'h2, 1'b1, 1'b1));
      @(negedge clk);
      chk("en_fwdValue", 32'(fwdValue), 32'd6);
      chk("ld_stall_comb", 32'(stall), 32'd1);
      tick();
      bufferIn = '0;
      @(negedge clk);
      chk("ld_memReq", 32'(memReq), 32'd1);
      chk("ld_memAddr", 32'(memAddr), 32'd5);
      chk("ld_memWe", 32'(memWe), 32'd0);
      chk("ld_bubble0", 32'(bufferOut), 32'd0);
      chk("ld_stall0", 32'(stall), 32'd1);
      tick();
      @(negedge clk);
      chk("ld_bubble1", 32'(bufferOut), 32'd0);
      chk("ld_stall1", 32'(stall), 32'd1);
      tick();
      memAck = 1'b1; memRdata = 4'h9;
      @(negedge clk);
      chk("ld_stall_ack", 32'(stall), 32'd0);
      tick();
      // Zero-wait store with memToReg also set: treated as a store
      memAck = 1'b0; memRdata = '0;
      bufferIn = mk(4'h7, 4'h5, 1'b0, 1'b1, 1'b1, 4'h3);
      sb.push_back(mko(4'h3, 4'h0, 4'h5, 1'b0, 1'b0));
      @(negedge clk);
      chk("ld_fwdValue", 32'(fwdValue), 32'd9);
      chk("ld_memReq_drop", 32'(memReq), 32'd0);
      chk("st_stall_comb", 32'(stall), 32'd1);
      tick();
      bufferIn = '0; memAck = 1'b1; memRdata = 4'hE;
      @(negedge clk);
      chk("st_memReq", 32'(memReq), 32'd1);
      chk("st_memWe", 32'(memWe), 32'd1);
      chk("st_memAddr", 32'(memAddr), 32'd3);
      chk("st_memWdata", 32'(memWdata), 32'd7);
      chk("st_stall_ack", 32'(stall), 32'd0);
      tick();
      // Reset in the middle of an access; a late ack is ignored
      memAck = 1'b0; memRdata = '0;
      bufferIn = mk(4'h0, 4'h4, 1'b1, 1'b1, 1'b0, 4'h8);
      @(negedge clk);
      chk("st_memReq_drop", 32'(memReq), 32'd0);
      chk("st_fwdRegWrite", 32'(fwdRegWrite), 32'd0);
      tick();
      bufferIn = '0; rst = 1'b0;
      @(negedge clk);
      chk("mid_memReq", 32'(memReq), 32'd1);
      chk("mid_stall_rst", 32'(stall), 32'd0);
      tick();
      rst = 1'b1; memAck = 1'b1; memRdata = 4'h3;
      @(negedge clk);
      chk("mid_memReq_rst", 32'(memReq), 32'd0);
      chk("mid_bufferOut_rst", 32'(bufferOut), 32'd0);
      chk("mid_stall_idle", 32'(stall), 32'd0);
      tick();
      memAck = 1'b0; memRdata = '0;
      bufferIn = mk(4'h0, 4'h6, 1'b1, 1'b1, 1'b0, 4'hC);
      @(negedge clk);
      chk("late_ack_bufferOut", 32'(bufferOut), 32'd0);
      chk("late_ack_memReq", 32'(memReq), 32'd0);
      tick();
      bufferIn = '0;
`ifdef MEM_STAGE_TIMEOUT_EN
      // No ack: abort after eight ACCESS cycles
      sb.push_back(mko(4'hC, 4'h0, 4'h6, 1'b0, 1'b1));
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("to_memReq", 32'(memReq), 32'd1);
         chk("to_stall", 32'(stall), (i == 7) ? 32'd0 : 32'd1);
         chk("to_memError_pre", 32'(memError), 32'd0);
         tick();
      end
      @(negedge clk);
      chk("to_memReq_drop", 32'(memReq), 32'd0);
      chk("to_memError", 32'(memError), 32'd1);
      chk("to_stall_after", 32'(stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("to_memError_sticky", 32'(memError), 32'd1);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("to_memError_clr", 32'(memError), 32'd0);
`else
      // No timeout: the access waits for the ack indefinitely
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("wait_memReq", 32'(memReq), 32'd1);
         chk("wait_stall", 32'(stall), 32'd1);
         chk("wait_memError", 32'(memError), 32'd0);
         tick();
      end
      memAck = 1'b1; memRdata = 4'h2;
      sb.push_back(mko(4'hC, 4'h2, 4'h6, 1'b1, 1'b1));
      @(negedge clk);
      chk("wait_stall_ack", 32'(stall), 32'd0);
      tick();
      memAck = 1'b0; memRdata = '0;
      @(negedge clk);
      chk("wait_memReq_drop", 32'(memReq), 32'd0);
      chk("wait_fwdValue", 32'(fwdValue), 32'd2);
`endif
      tick(); tick();
      @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      stim_done = 1'b1;
   endtask

   initial begin
      fork
         stimulus();
         monitor();
      join
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer of the execute stage's EX/MEM buffer.
- Unpacks the buffer and performs the data-memory load or store over a req/ack handshake. Stalls upstream while an access is outstanding.
- Registers a MEM/WB buffer for writeback and drives forwarding outputs back to the execute stage.

Parameters:
- N, 4, datapath width (rd3, aluResult, memory data and address).
- BW, 26, input buffer width; must equal 2N+18.
- OW, 14, output buffer width; must equal 2N+6.
- TIMEOUT, 8, maximum cycles spent in ACCESS before abort (only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- en  in  1  stage enable
- bufferIn  in  BW  EX/MEM buffer: [N-1:0] rd3, [N+3:N] Rc, [N+7:N+4] Rb, [N+11:N+8] Ra, [N+12] regWrite, [N+13] memToReg, [N+14] memWrite, [N+15] branchFlag, [N+16] negFlag, [N+17] zeroFlag, [2N+17:N+18] aluResult
- memReq  out  1  memory request
- memWe  out  1  write strobe, valid while memReq=1
- memAddr  out  N  address
- memWdata  out  N  store data
- memAck  in  1  memory acknowledge
- memRdata  in  N  load data, valid when memAck=1
- stall  out  1  freeze upstream stages
- bufferOut  out  OW  MEM/WB buffer: [N-1:0] aluResult, [2N-1:N] memData, [2N+3:2N] Rc, [2N+4] regWrite, [2N+5] memToReg
- fwdRegWrite  out  1  bufferOut regWrite
- fwdRc  out  4  bufferOut Rc
- fwdValue  out  N  memToReg ? memData : aluResult, taken from bufferOut
- memError  out  1  sticky timeout flag

Behaviour:
- Reset: sampled at posedge, rst=0 wins over everything.
  - State returns to IDLE.
  - bufferOut=0, memReq=0, memWe=0, memAddr=0, memWdata=0, memError=0, timeout counter=0.
  - stall=0 while rst=0.
- isMem = memToReg | memWrite of bufferIn.
- FSM states: IDLE, ACCESS.
- IDLE, en=1, !isMem:
  - bufferOut loads {memToReg, regWrite, Rc, memData=0, aluResult} at the next edge.
  - Latency 1 cycle; stall=0.
- IDLE, en=1, isMem:
  - stall=1 combinationally in the same cycle.
  - At the edge: hold register captures the entry, memAddr=aluResult, memWdata=rd3, memWe=memWrite, memReq=1, state goes to ACCESS.
  - bufferOut loads a bubble (all zero).
- ACCESS:
  - memReq, memWe, memAddr and memWdata stay stable until ack.
  - stall = !memAck.
  - On memAck=1 at an edge: bufferOut loads the held entry with memData=memRdata (0 for a store), memReq drops to 0, state goes to IDLE.
  - Each cycle without ack loads a bubble into bufferOut.
  - Minimum load/store latency: 2 edges (zero-wait ack).
- en=0: state, bufferOut, memory outputs and counter all hold; stall=0 in IDLE, = !memAck in ACCESS.
  - An ack arriving while en=0 in ACCESS is still captured; the memory side is not gated.
- memAck while memReq=0: ignored.
- A load and store together (memToReg=memWrite=1) is treated as a store; memWe=1 and bufferOut memToReg=0.
- branchFlag, negFlag, zeroFlag, Ra and Rb are consumed upstream and are not forwarded.
- Forwarding outputs are purely combinational from bufferOut.

Optional Feature:
- Macro: MEM_STAGE_TIMEOUT_EN.
- Defined:
  - A counter increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT-1 without ack, at the next edge: memReq=0, state goes to IDLE, memError=1 (sticky until reset).
  - bufferOut loads the held entry with regWrite=0 and memData=0; stall releases in that cycle.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - memError is tied 0.

Test Plan:
- ALU pass-through: aluResult=4, Rc=3, regWrite=1, memToReg=memWrite=0 -> after 1 edge bufferOut aluResult=4, Rc=3, regWrite=1; fwdValue=4; memReq and stall stay 0.
- Load with 2-cycle ack delay: aluResult=5, Rc=2, memToReg=1, regWrite=1 -> stall=1 immediately; next cycle memReq=1, memAddr=5, memWe=0; ack with memRdata=9 two cycles later -> bufferOut memData=9, fwdValue=9, stall=0 in the ack cycle, bubbles before it.
- Zero-wait store: rd3=7, aluResult=3, memWrite=1 -> memReq=1, memWe=1, memAddr=3, memWdata=7; ack in the first request cycle -> exactly one stalled edge; bufferOut regWrite=0.
- Reset mid-access: rst=0 while memReq=1 -> after the edge memReq=0, bufferOut=0, stall=0, state IDLE; a late memAck=1 is ignored.
- Enable hold: en=0 with aluResult=6 pending in IDLE -> bufferOut unchanged over 3 edges; en=1 -> loads 6.
- Timeout (macro defined, TIMEOUT=8): load issued, no ack -> memReq drops after 8 ACCESS cycles, memError=1, bufferOut regWrite=0, stall=0; memError stays 1 until rst=0.
